// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read forwarding and a
// per-register busy scoreboard used for hazard detection in the ID stage.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREAD*ADDR_W-1:0]  raddr,
    output logic [NREAD*DATA_W-1:0]  rdata,
    output logic [NREAD-1:0]         rbusy,
    input  logic [NWRITE-1:0]        we,
    input  logic [NWRITE*ADDR_W-1:0] waddr,
    input  logic [NWRITE*DATA_W-1:0] wdata,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;

    logic [ADDR_W-1:0] wr_addr [NWRITE];
    logic [DATA_W-1:0] wr_data [NWRITE];
    logic [NWRITE-1:0] wr_ok;
    logic              iss_ok;

    // A write or issue aimed at a hardwired zero register is treated as absent.
    for (genvar j = 0; j < NWRITE; j++) begin : g_wport
        assign wr_addr[j] = waddr[j*ADDR_W +: ADDR_W];
        assign wr_data[j] = wdata[j*DATA_W +: DATA_W];
        assign wr_ok[j]   = we[j] && !((ZERO_REG != 0) && (wr_addr[j] == '0));
    end

    assign iss_ok = issue_valid && !((ZERO_REG != 0) && (issue_addr == '0));

    // Later ports are assigned last, so the highest-index writer wins a conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                rf[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_ok[j]) begin
                    rf[wr_addr[j]] <= wr_data[j];
                end
            end
        end
    end

    // Retiring writes clear first so a new producer to the same register keeps it busy.
    always_comb begin
        busy_next = busy;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_ok[j]) begin
                busy_next[wr_addr[j]] = 1'b0;
            end
        end
        if (iss_ok) begin
            busy_next[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rport
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] fwd_data;
        logic              fwd_hit;
        logic              zero_hit;

        assign ra       = raddr[i*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);

        always_comb begin
            fwd_hit  = 1'b0;
            fwd_data = rf[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (wr_ok[j] && (wr_addr[j] == ra)) begin
                        fwd_hit  = 1'b1;
                        fwd_data = wr_data[j];
                    end
                end
            end
        end

        // Reset masks the forwarding path too, so nothing leaks out while it is held.
        assign rdata[i*DATA_W +: DATA_W] = (reset || zero_hit) ? '0 : fwd_data;
        assign rbusy[i] = busy[ra] && !(reset || zero_hit || fwd_hit);
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file. It is the successor of the single-issue 2R1W register file. It adds N read ports, M write ports, asynchronous reset clearing, optional write-to-read bypass, and a per-register busy scoreboard for pipeline hazard detection. It sits in the ID stage: read ports serve operand fetch, write ports serve WB lanes, and the issue port marks destination registers pending.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NREAD, 2, number of read ports (>=1)
NWRITE, 1, number of write ports (>=1)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
raddr  input  NREAD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
rdata  output  NREAD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
rbusy  output  NREAD  scoreboard busy flag of each read address
we  input  NWRITE  per-port write enable, high valid
waddr  input  NWRITE*ADDR_W  write addresses, packed as raddr
wdata  input  NWRITE*DATA_W  write data, packed as rdata
issue_valid  input  1  marks issue_addr as having an in-flight producer
issue_addr  input  ADDR_W  destination register of the issuing instruction

Behaviour:
- Reset (asynchronous, active-high): all 2**ADDR_W registers clear to 0 and all busy bits clear to 0 immediately, with no clock needed. While reset is high, rdata returns 0 on every port (bypass path included) and rbusy is all 0. Writes and issues presented during reset are discarded. Deassertion mid-operation leaves the array all-zero.
- Write: on posedge clk, for each port j with we[j]=1, rf[waddr_j] <= wdata_j.
- Write conflict: several ports writing the same address in one cycle → the highest-index port wins. Writes to different addresses all take effect in the same cycle.
- Zero register: with ZERO_REG=1, writes to address 0 are dropped, reads of address 0 return 0 and rbusy for address 0 is 0, regardless of bypass. With ZERO_REG=0, register 0 is an ordinary register.
- Read: combinational, zero latency.
  - BYPASS=0: rdata_i = rf[raddr_i], i.e. the pre-edge value.
  - BYPASS=1: if any port j has we[j]=1 and waddr_j==raddr_i (and the address is not the suppressed register 0), rdata_i = wdata of the highest such j. Otherwise rdata_i = rf[raddr_i].
- Scoreboard, one busy bit per register, updated on posedge:
  - issue_valid=1 sets busy[issue_addr].
  - we[j]=1 clears busy[waddr_j].
  - Same address set and cleared in one cycle: set wins, because the new producer supersedes the retiring one.
  - issue_valid to address 0 with ZERO_REG=1 is ignored.
- rbusy_i = busy[raddr_i], except forced to 0 in two cases:
  - BYPASS=1 and a write to raddr_i is active this cycle, since the value is forwarded.
  - address 0 with ZERO_REG=1.
- The issue port does not affect rbusy in the same cycle; it takes effect at the next cycle.
- No internal protection against write-after-write ordering; the pipeline guarantees it.
- All address arithmetic is unsigned, ADDR_W bits, with no wrap logic needed; every index is in range.

Test Plan:
- Reset sanity: preload r5=0x1234_5678 and set busy[5]. Assert reset asynchronously between clock edges → rdata for raddr=5 is 0x0 immediately and rbusy=0; after release it still reads 0x0.
- Basic write/read with BYPASS=0, NREAD=2, NWRITE=1:
  - Write r3=0xDEAD_BEEF. In the same cycle raddr0=3 → rdata0 shows the old value 0x0.
  - Next cycle → 0xDEAD_BEEF on both ports when raddr0=raddr1=3.
- Bypass with BYPASS=1: we=1, waddr=7, wdata=0xA5A5_0001, raddr1=7 → rdata1=0xA5A5_0001 in the same cycle, and rbusy1=0 even though busy[7] was set.
- Dual-write conflict with NWRITE=2: both ports write r9, port0 0x1111 and port1 0x2222 → r9 reads 0x2222 next cycle, and the bypass in the same cycle also gives 0x2222. Separately, r10 and r11 written in the same cycle → both updated.
- Zero register:
  - Write r0=0xFFFF_FFFF and issue to r0 → reads 0, rbusy=0, including via bypass.
  - With ZERO_REG=0 the same stimulus → r0 reads 0xFFFF_FFFF.
- Scoreboard race: busy[4]=1; in one cycle issue_addr=4 and we writes r4=0x77 → next cycle busy[4]=1 and r4=0x77. A write without an issue in the following cycle clears it to 0.
